bcd_scan_driver: RTL and testbench

- Time-multiplexes NUM_DIGITS packed BCD digits onto one shared 4-bit bcd bus that feeds the bcd input of the BCD-to-7-segment decoder.
- Generates active-low one-hot digit-enable (anode) strobes in lock-step with the bus.
- Sits directly upstream of the decoder. The decoder's seg output plus this block's an output drive a multiplexed common-anode display.

---
 rtl/bcd_disp_pkg.sv | 24 ++
 rtl/prescaler_tick.sv | 43 ++++
 rtl/bcd_scan_driver.sv | 133 +++++++++++++
 tb/tb_bcd_scan_driver.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
// ---------------------------------------------------------------------------
// bcd_disp_pkg
// Shared constants and helpers for the multiplexed BCD display blocks.
//   BCD_W      : width of one BCD digit code
//   MAX_DIGITS : largest digit count any display block supports
//   VEC_W      : width of a packed digit vector at MAX_DIGITS
//   AN_OFF     : all-ones anode pattern (every digit dark); slice to width
//   digit_sel  : extract nibble idx from a packed digit vector
// ---------------------------------------------------------------------------
package bcd_disp_pkg;

  localparam int BCD_W      = 4;
  localparam int MAX_DIGITS = 8;
  localparam int VEC_W      = BCD_W * MAX_DIGITS;

  localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;

  // Callers zero-extend narrower vectors and indices to the full widths.
  function automatic logic [BCD_W-1:0] digit_sel(input logic [VEC_W-1:0] vec,
                                                 input logic [2:0]       idx);
    return vec[int'(idx)*BCD_W +: BCD_W];
  endfunction

endpackage

// File: rtl/prescaler_tick.sv
// ---------------------------------------------------------------------------
// prescaler_tick
// Free-running modulo-PRESCALE counter shared by the display and debounce
// blocks. Counts 0..PRESCALE-1 and wraps.
// Ports:
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset, clears the count to 0
//   tick    : high while the count is at its terminal value PRESCALE-1
//   at_zero : high while the count is 0
// Parameters:
//   PRESCALE : cycles per period, minimum 2
// ---------------------------------------------------------------------------
module prescaler_tick #(
  parameter int PRESCALE = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick,
  output logic at_zero
);

  localparam int               CNT_W = $clog2(PRESCALE);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick    = (cnt_q == LAST);
  assign at_zero = (cnt_q == '0);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bcd_scan_driver.sv
// ---------------------------------------------------------------------------
// bcd_scan_driver
// Time-multiplexes NUM_DIGITS packed BCD digits onto one 4-bit bus feeding a
// BCD-to-7-segment decoder, with active-low one-hot anode strobes for a
// common-anode display. New digits are double-buffered (pending -> active)
// and only take effect at a frame boundary, so a frame never mixes loads.
// Ports:
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset, blanks the display at once
//   digits_in   : packed BCD digits, digit k = digits_in[4k+3:4k], k=0 rightmost
//   load        : capture digits_in into the pending buffer
//   bcd         : registered current digit code
//   an          : registered active-low digit enables, at most one bit low
//   frame_start : registered one-cycle pulse as digit 0's slot begins
// Parameters:
//   NUM_DIGITS : 2..8
//   PRESCALE   : clk cycles per digit slot, minimum 2
// Build option:
//   BCD_SCAN_LEADING_ZERO_BLANK_EN : when defined, digits above the most
//   significant non-zero digit stay dark (digit 0 is always lit).
// ---------------------------------------------------------------------------
module bcd_scan_driver
  import bcd_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [BCD_W*NUM_DIGITS-1:0] digits_in,
  input  logic                        load,
  output logic [BCD_W-1:0]            bcd,
  output logic [NUM_DIGITS-1:0]       an,
  output logic                        frame_start
);

  localparam int                  IDX_W    = $clog2(NUM_DIGITS);
  localparam int                  DIG_W    = BCD_W * NUM_DIGITS;
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = AN_OFF[NUM_DIGITS-1:0];

  logic                  tick;
  logic                  at_zero;
  logic                  wrap;

  logic [IDX_W-1:0]      idx_q,         idx_d;
  logic [DIG_W-1:0]      pending_q,     pending_d;
  logic [DIG_W-1:0]      active_q,      active_d;
  logic [BCD_W-1:0]      bcd_q,         bcd_d;
  logic [NUM_DIGITS-1:0] an_q,          an_d;
  logic                  frame_start_q, frame_start_d;
  logic [NUM_DIGITS-1:0] lit_mask;

  prescaler_tick #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .at_zero (at_zero)
  );

  // Frame boundary: the edge on which the digit index wraps back to 0.
  assign wrap = tick && (idx_q == IDX_LAST);

  // Slot index advances once per prescaler period.
  always_comb begin
    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Double buffer. Using pending_d on the boundary gives the load bypass:
  // a load coinciding with the wrap edge lands in the very next frame.
  always_comb begin
    pending_d = load ? digits_in : pending_q;
    active_d  = wrap ? pending_d : active_q;
  end

`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
  logic seen_nz;

  // Walk from the top digit down: a digit is lit once any digit at or above
  // it is non-zero. Derived from active only, so it is stable for a frame.
  always_comb begin
    seen_nz  = 1'b0;
    lit_mask = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      seen_nz     = seen_nz | (active_q[k*BCD_W +: BCD_W] != '0);
      lit_mask[k] = seen_nz;
    end
    lit_mask[0] = 1'b1;
  end
`else
  assign lit_mask = '1;
`endif

  // Outputs are computed from pre-edge state; the first cycle of every slot
  // is dead time with all anodes off to suppress ghosting.
  always_comb begin
    bcd_d         = digit_sel(VEC_W'(active_q), 3'(idx_q));
    an_d          = ~(NUM_DIGITS'(1) << idx_q);
    if (at_zero || !lit_mask[idx_q]) begin
      an_d = AN_ALL_OFF;
    end
    frame_start_d = at_zero && (idx_q == '0);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q         <= '0;
      pending_q     <= '0;
      active_q      <= '0;
      bcd_q         <= '0;
      an_q          <= AN_ALL_OFF;
      frame_start_q <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      pending_q     <= pending_d;
      active_q      <= active_d;
      bcd_q         <= bcd_d;
      an_q          <= an_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bcd         = bcd_q;
  assign an          = an_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_bcd_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_bcd_scan_driver
// Self-checking bench for bcd_scan_driver (NUM_DIGITS=4, PRESCALE=4).
// The reference model works from the cycle count since reset: slot and
// digit position come from plain division, and the displayed value is the
// last load captured before the most recent frame boundary.
// ---------------------------------------------------------------------------
module tb_bcd_scan_driver;

  localparam int N = 4;
  localparam int P = 4;
  localparam int FRAME = N * P;

  logic          clk;
  logic          rst_n;
  logic [4*N-1:0] digitsIn;
  logic          load;
  logic [3:0]    bcd;
  logic [N-1:0]  an;
  logic          frameStart;

  int checkCount;
  int errorCount;

  // Model state: edges seen since reset release, plus the two digit buffers
  int          modelCycle;
  logic [15:0] pendingM;
  logic [15:0] activeM;

  bcd_scan_driver #(
    .NUM_DIGITS (N),
    .PRESCALE   (P)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digits_in   (digitsIn),
    .load        (load),
    .bcd         (bcd),
    .an          (an),
    .frame_start (frameStart)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
               tag, observed, expected, modelCycle);
    end
  endtask

  // Is digit k shown for this active value?
  function automatic logic digitLit(input logic [15:0] act, input int k);
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
    int msd;
    msd = 0;
    for (int j = 0; j < N; j++) begin
      if (act[j*4 +: 4] != 4'd0) msd = j;
    end
    return (k <= msd);
`else
    return 1'b1;
`endif
  endfunction

  // Drive one cycle of inputs at the negedge, predict the outputs of the
  // following rising edge, then compare at the next negedge.
  task automatic applyStimulus(input logic ld, input logic [15:0] dv);
    int          slotPos;
    int          digitPos;
    logic [3:0]  expBcd;
    logic [N-1:0] expAn;
    logic        expFs;
    load     = ld;
    digitsIn = dv;
    @(posedge clk);
    slotPos  = modelCycle % P;
    digitPos = (modelCycle / P) % N;
    expBcd   = activeM[digitPos*4 +: 4];
    if (slotPos == 0 || !digitLit(activeM, digitPos)) expAn = '1;
    else expAn = ~(N'(1) << digitPos);
    expFs = (slotPos == 0) && (digitPos == 0);
    if (ld) pendingM = dv;
    if (modelCycle % FRAME == FRAME - 1) activeM = pendingM;
    modelCycle++;
    @(negedge clk);
    checkOutput("bcd", 32'(bcd), 32'(expBcd));
    checkOutput("an", 32'(an), 32'(expAn));
    checkOutput("frame_start", 32'(frameStart), 32'(expFs));
  endtask

  // Random BCD-ish value; codes 10..15 appear occasionally on purpose
  function automatic logic [15:0] randDigits();
    logic [15:0] v;
    v = 16'($urandom);
    if ($urandom_range(3) == 0) v[15:8] = 8'h00;
    return v;
  endfunction

  task automatic resetModel();
    modelCycle = 0;
    pendingM   = '0;
    activeM    = '0;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    resetModel();
    load     = 1'b0;
    digitsIn = '0;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_an", 32'(an), 32'hF);
    checkOutput("rst_bcd", 32'(bcd), 32'h0);
    checkOutput("rst_fs", 32'(frameStart), 32'h0);
    rst_n = 1'b1;

    // Basic scan: one load, then idle for the frame it takes to appear and
    // the frame that shows it
    applyStimulus(1'b1, 16'h4321);
    repeat (2 * FRAME + 3) applyStimulus(1'b0, 16'h0000);

    // Tear-free update: 5678 displayed, 1234 loaded mid-frame
    while (modelCycle % FRAME != FRAME - 1) applyStimulus(1'b0, 16'h0000);
    applyStimulus(1'b1, 16'h5678);
    repeat (FRAME + 6) applyStimulus(1'b0, 16'h0000);
    applyStimulus(1'b1, 16'h1234);
    repeat (2 * FRAME) applyStimulus(1'b0, 16'h0000);

    // Load exactly on the wrap edge
    while (modelCycle % FRAME != FRAME - 1) applyStimulus(1'b0, 16'h0000);
    applyStimulus(1'b1, 16'h9999);
    repeat (FRAME) applyStimulus(1'b0, 16'h0000);

    // Leading-zero patterns and all zeros
    applyStimulus(1'b1, 16'h0050);
    repeat (2 * FRAME) applyStimulus(1'b0, 16'h0000);
    applyStimulus(1'b1, 16'h0000);
    repeat (2 * FRAME) applyStimulus(1'b0, 16'h0000);

    // Randomized loads, with extra weight on the boundary edge
    for (int i = 0; i < 400; i++) begin
      logic ld;
      ld = ($urandom_range(7) == 0) ||
           ((modelCycle % FRAME == FRAME - 1) && ($urandom_range(1) == 0));
      applyStimulus(ld, randDigits());
    end

    // Asynchronous reset mid-scan: outputs blank without waiting for a clock
    applyStimulus(1'b1, 16'h8888);
    repeat (FRAME + 5) applyStimulus(1'b0, 16'h0000);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_an", 32'(an), 32'hF);
    checkOutput("async_rst_bcd", 32'(bcd), 32'h0);
    checkOutput("async_rst_fs", 32'(frameStart), 32'h0);
    @(negedge clk);
    resetModel();
    rst_n = 1'b1;

    // After reset the display shows zeros until a load crosses a boundary
    repeat (FRAME + 2) applyStimulus(1'b0, 16'h0000);
    for (int i = 0; i < 200; i++) begin
      applyStimulus($urandom_range(5) == 0, randDigits());
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
